// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   state_e          : FSM encoding (FETCH / WAIT / HOLD)
//   XLEN             : address/data width
//   RESET_PC_DEFAULT : default reset PC
//   PC_INC_DEFAULT   : default sequential PC step in bytes
//   WORD_ALIGN_MASK  : clears bits [1:0] of redirect addresses
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned     PC_INC_DEFAULT   = 4;
  localparam logic [XLEN-1:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  // Force a redirect target onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection for the fetch stage.
// Ports:
//   pc_q      in  current PC
//   flush     in  restart at flush_pc (highest priority)
//   flush_pc  in  restart address
//   consume   in  downstream accepts held instruction this cycle
//   pc_src    in  take branch on consume
//   result    in  branch target
//   pc_d      out next PC value
//   pc_plus8  out pc_q + 8
module fetch_unit_pc_next
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_INC = PC_INC_DEFAULT
) (
  input  logic [XLEN-1:0] pc_q,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            consume,
  input  logic            pc_src,
  input  logic [XLEN-1:0] result,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus8
);

  // Flush > consume&branch > consume > hold; adders wrap at 2^32.
  always_comb begin
    pc_d = pc_q;
    if (flush) begin
      pc_d = word_align(flush_pc);
    end else if (consume) begin
      if (pc_src) pc_d = word_align(result);
      else        pc_d = pc_q + XLEN'(PC_INC);
    end
  end

  assign pc_plus8 = pc_q + XLEN'(8);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding request at a
// time to instruction memory, and holds the fetched word until downstream
// accepts it. Handles branch redirects and an overriding flush.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   IMemReq/IMemAddr              request valid / word address to memory
//   IMemReady                     memory accepts request this cycle
//   IMemRValid/IMemRData          response valid / word
//   Stall                         downstream not accepting Instr
//   PCSrc/Result                  branch taken / target (on consume)
//   Flush/FlushPC                 squash everything, restart address
//   Instr/InstrValid/PC           held instruction, valid, its address
//   PCPlus8                       PC + 8 (combinational)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_INC   = PC_INC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  input  logic        Stall,
  input  logic        PCSrc,
  input  logic [31:0] Result,
  input  logic        Flush,
  input  logic [31:0] FlushPC,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus8
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              discard_q, discard_d;
  logic              req_q, req_d;
  logic              consume;

  // Next-PC mux and PC+8.
  fetch_unit_pc_next #(
    .PC_INC (PC_INC)
  ) u_pc_next (
    .pc_q     (pc_q),
    .flush    (Flush),
    .flush_pc (FlushPC),
    .consume  (consume),
    .pc_src   (PCSrc),
    .result   (Result),
    .pc_d     (pc_d),
    .pc_plus8 (PCPlus8)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= word_align(RESET_PC);
      instr_q   <= '0;
      valid_q   <= 1'b0;
      discard_q <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      discard_q <= discard_d;
      req_q     <= req_d;
    end
  end

  // Next-state, squash flag and instruction capture.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    consume   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        // An accepted request always gets a response; a flush here marks it stale.
        if (req_q && IMemReady) begin
          state_d = ST_WAIT;
          if (Flush) discard_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (IMemRValid) begin
          if (Flush || discard_q) begin
            discard_d = 1'b0;
            state_d   = ST_FETCH;
          end else begin
            instr_d = IMemRData;
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end
        end else if (Flush) begin
          discard_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (Flush) begin
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end else if (!Stall) begin
          consume = 1'b1;
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Request is registered so it is low through reset and rises one cycle after.
  assign req_d      = (state_d == ST_FETCH);

  assign IMemReq    = req_q;
  assign IMemAddr   = pc_q;
  assign Instr      = instr_q;
  assign InstrValid = valid_q;
  assign PC         = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic        IMemRValid;
  logic [31:0] IMemRData;
  logic        Stall;
  logic        PCSrc;
  logic [31:0] Result;
  logic        Flush;
  logic [31:0] FlushPC;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus8;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemReady  (IMemReady),
    .IMemRValid (IMemRValid),
    .IMemRData  (IMemRData),
    .Stall      (Stall),
    .PCSrc      (PCSrc),
    .Result     (Result),
    .Flush      (Flush),
    .FlushPC    (FlushPC),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .PC         (PC),
    .PCPlus8    (PCPlus8)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Accept the current request and return data one cycle later; ends in HOLD.
  task automatic do_fetch(input logic [31:0] data);
    IMemReady = 1'b1;
    tick();
    IMemReady  = 1'b0;
    IMemRValid = 1'b1;
    IMemRData  = data;
    tick();
    IMemRValid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; IMemReady = 1'b0; IMemRValid = 1'b0; IMemRData = '0;
    Stall = 1'b0; PCSrc = 1'b0; Result = '0; Flush = 1'b0; FlushPC = '0;
    tick(); tick();
    total_cnt++; if (IMemReq !== 1'b0) $display("FAIL rst_req: got %b want 0", IMemReq); else pass_cnt++;
    total_cnt++; if (InstrValid !== 1'b0) $display("FAIL rst_valid: got %b want 0", InstrValid); else pass_cnt++;
    total_cnt++; if (Instr !== 32'h0) $display("FAIL rst_instr: got %h want 0", Instr); else pass_cnt++;
    total_cnt++; if (PC !== 32'h0) $display("FAIL rst_pc: got %h want 0", PC); else pass_cnt++;
    reset = 1'b0;
    tick();
    total_cnt++; if (IMemReq !== 1'b1) $display("FAIL rst_req_after: got %b want 1", IMemReq); else pass_cnt++;
    total_cnt++; if (IMemAddr !== 32'h0) $display("FAIL rst_addr_after: got %h want 0", IMemAddr); else pass_cnt++;
  endtask

  // Two instructions at 0 and 4, 3 cycles each with 1-cycle memory.
  task automatic test_sequential();
    logic [31:0] data [2];
    data[0] = 32'hE3A0_0001;
    data[1] = 32'hE280_0002;
    for (int i = 0; i < 2; i++) begin
      total_cnt++; if (IMemReq !== 1'b1) $display("FAIL seq_req[%0d]: got %b want 1", i, IMemReq); else pass_cnt++;
      total_cnt++; if (IMemAddr !== 32'(4*i)) $display("FAIL seq_addr[%0d]: got %h want %h", i, IMemAddr, 32'(4*i)); else pass_cnt++;
      IMemReady = 1'b1;
      tick();
      IMemReady = 1'b0;
      total_cnt++; if (IMemReq !== 1'b0) $display("FAIL seq_wait_req[%0d]: got %b want 0", i, IMemReq); else pass_cnt++;
      IMemRValid = 1'b1; IMemRData = data[i];
      tick();
      IMemRValid = 1'b0;
      total_cnt++; if (InstrValid !== 1'b1) $display("FAIL seq_valid[%0d]: got %b want 1", i, InstrValid); else pass_cnt++;
      total_cnt++; if (Instr !== data[i]) $display("FAIL seq_instr[%0d]: got %h want %h", i, Instr, data[i]); else pass_cnt++;
      total_cnt++; if (PC !== 32'(4*i)) $display("FAIL seq_pc[%0d]: got %h want %h", i, PC, 32'(4*i)); else pass_cnt++;
      total_cnt++; if (PCPlus8 !== 32'(4*i+8)) $display("FAIL seq_pc8[%0d]: got %h want %h", i, PCPlus8, 32'(4*i+8)); else pass_cnt++;
      tick();
      total_cnt++; if (InstrValid !== 1'b0) $display("FAIL seq_consumed[%0d]: got %b want 0", i, InstrValid); else pass_cnt++;
    end
  endtask

  // Memory not ready for 4 cycles at 0x8.
  task automatic test_ready_low();
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h8 || InstrValid !== 1'b0)
        $display("FAIL rdy_low[%0d]: got req=%b addr=%h valid=%b want req=1 addr=00000008 valid=0", i, IMemReq, IMemAddr, InstrValid);
      else pass_cnt++;
      tick();
    end
    do_fetch(32'h1111_2222);
    total_cnt++; if (InstrValid !== 1'b1 || Instr !== 32'h1111_2222 || PC !== 32'h8)
      $display("FAIL rdy_low_hold: got valid=%b instr=%h pc=%h want 1 11112222 00000008", InstrValid, Instr, PC);
    else pass_cnt++;
  endtask

  // Stall in HOLD for 3 cycles, then branch to 0x103 (aligned to 0x100).
  task automatic test_stall_branch();
    Stall = 1'b1; PCSrc = 1'b1; Result = 32'h0000_0777;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if (InstrValid !== 1'b1 || Instr !== 32'h1111_2222 || PC !== 32'h8 || IMemReq !== 1'b0)
        $display("FAIL stall[%0d]: got valid=%b instr=%h pc=%h req=%b want 1 11112222 00000008 0", i, InstrValid, Instr, PC, IMemReq);
      else pass_cnt++;
    end
    Stall = 1'b0; Result = 32'h0000_0103;
    tick();
    PCSrc = 1'b0;
    total_cnt++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h100)
      $display("FAIL branch_addr: got req=%b addr=%h want 1 00000100", IMemReq, IMemAddr);
    else pass_cnt++;
  endtask

  // Flush in WAIT; response two cycles later is dropped.
  task automatic test_flush_wait();
    IMemReady = 1'b1;
    tick();
    IMemReady = 1'b0;
    Flush = 1'b1; FlushPC = 32'h40;
    tick();
    Flush = 1'b0;
    total_cnt++; if (IMemReq !== 1'b0 || PC !== 32'h40)
      $display("FAIL flw_wait: got req=%b pc=%h want 0 00000040", IMemReq, PC);
    else pass_cnt++;
    tick();
    IMemRValid = 1'b1; IMemRData = 32'h0000_DEAD;
    tick();
    IMemRValid = 1'b0;
    total_cnt++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h40 || InstrValid !== 1'b0)
      $display("FAIL flw_drop: got req=%b addr=%h valid=%b want 1 00000040 0", IMemReq, IMemAddr, InstrValid);
    else pass_cnt++;
    tick();
    total_cnt++; if (InstrValid !== 1'b0 || IMemAddr !== 32'h40)
      $display("FAIL flw_still: got valid=%b addr=%h want 0 00000040", InstrValid, IMemAddr);
    else pass_cnt++;
  endtask

  // Flush in the same cycle the request at 0x40 is accepted.
  task automatic test_flush_ready();
    IMemReady = 1'b1; Flush = 1'b1; FlushPC = 32'h80;
    tick();
    IMemReady = 1'b0; Flush = 1'b0;
    total_cnt++; if (IMemReq !== 1'b0 || PC !== 32'h80)
      $display("FAIL flr_wait: got req=%b pc=%h want 0 00000080", IMemReq, PC);
    else pass_cnt++;
    IMemRValid = 1'b1; IMemRData = 32'h0000_0BAD;
    tick();
    IMemRValid = 1'b0;
    total_cnt++; if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 32'h80)
      $display("FAIL flr_drop: got valid=%b req=%b addr=%h want 0 1 00000080", InstrValid, IMemReq, IMemAddr);
    else pass_cnt++;
    do_fetch(32'h8080_0001);
    total_cnt++; if (InstrValid !== 1'b1 || Instr !== 32'h8080_0001 || PC !== 32'h80)
      $display("FAIL flr_resume: got valid=%b instr=%h pc=%h want 1 80800001 00000080", InstrValid, Instr, PC);
    else pass_cnt++;
    tick();
  endtask

  // Flush to an unaligned top address, then sequential wrap to 0.
  task automatic test_wrap();
    Flush = 1'b1; FlushPC = 32'hFFFF_FFFF;
    tick();
    Flush = 1'b0;
    total_cnt++; if (IMemReq !== 1'b1 || IMemAddr !== 32'hFFFF_FFFC)
      $display("FAIL wrap_addr: got req=%b addr=%h want 1 fffffffc", IMemReq, IMemAddr);
    else pass_cnt++;
    do_fetch(32'hCAFE_F00D);
    total_cnt++; if (PCPlus8 !== 32'h4 || PC !== 32'hFFFF_FFFC || Instr !== 32'hCAFE_F00D)
      $display("FAIL wrap_hold: got pc8=%h pc=%h instr=%h want 00000004 fffffffc cafef00d", PCPlus8, PC, Instr);
    else pass_cnt++;
    tick();
    total_cnt++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0)
      $display("FAIL wrap_next: got req=%b addr=%h want 1 00000000", IMemReq, IMemAddr);
    else pass_cnt++;
  endtask

  // Flush in HOLD overrides Stall and PCSrc.
  task automatic test_flush_hold();
    do_fetch(32'h1234_5678);
    Flush = 1'b1; FlushPC = 32'h300; Stall = 1'b1; PCSrc = 1'b1; Result = 32'h200;
    tick();
    Flush = 1'b0; Stall = 1'b0; PCSrc = 1'b0;
    total_cnt++; if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 32'h300)
      $display("FAIL flh: got valid=%b req=%b addr=%h want 0 1 00000300", InstrValid, IMemReq, IMemAddr);
    else pass_cnt++;
  endtask

  // Reset while waiting; the stale response after reset must be ignored.
  task automatic test_reset_mid();
    IMemReady = 1'b1;
    tick();
    IMemReady = 1'b0;
    reset = 1'b1;
    tick();
    total_cnt++; if (IMemReq !== 1'b0 || PC !== 32'h0)
      $display("FAIL rmid_rst: got req=%b pc=%h want 0 00000000", IMemReq, PC);
    else pass_cnt++;
    reset = 1'b0; IMemRValid = 1'b1; IMemRData = 32'h0000_BEEF;
    tick();
    IMemRValid = 1'b0;
    total_cnt++; if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 32'h0)
      $display("FAIL rmid_ignore: got valid=%b req=%b addr=%h want 0 1 00000000", InstrValid, IMemReq, IMemAddr);
    else pass_cnt++;
    tick();
    total_cnt++; if (InstrValid !== 1'b0 || IMemReq !== 1'b1)
      $display("FAIL rmid_still: got valid=%b req=%b want 0 1", InstrValid, IMemReq);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_ready_low();
    test_stall_branch();
    test_flush_wait();
    test_flush_ready();
    test_wrap();
    test_flush_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
